sr_pulse_driver: RTL and testbench
==================================

Name: sr_pulse_driver

Overview:
- Upstream excitation stage for the SR flip-flops.
- Takes two raw, asynchronous, possibly bouncing push-button levels: set request and reset request.
- Synchronises and debounces each one, then converts each debounced rising edge into a single-cycle `s` or `r` pulse.
- Guarantees that `s` and `r` are never both 1, so the undefined SR input combination can never reach the downstream flip-flop.

Parameters:
- DEBOUNCE, 4: number of consecutive clock cycles a synchronised input must differ from its debounced level before the debounced level changes. Legal range is DEBOUNCE >= 2.
- CW, $clog2(DEBOUNCE): width of each debounce counter. Derived; not overridden.

Ports:
- ck  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- set_btn  input  1  raw set request, asynchronous to ck, may bounce.
- rst_btn  input  1  raw reset request, asynchronous to ck, may bounce.
- s  output  1  registered one-cycle set pulse for the SR flip-flop.
- r  output  1  registered one-cycle reset pulse for the SR flip-flop.
- conflict  output  1  registered one-cycle flag: set and reset edges were detected on the same cycle and both were suppressed.
- set_lvl  output  1  debounced level of set_btn (status).
- rst_lvl  output  1  debounced level of rst_btn (status).

Behaviour:
- Reset:
  - rst_n=0 forces all of the following to 0 immediately, independent of ck: both synchroniser registers, debounced levels, previous-level registers, counters, s, r and conflict.
- Datapath, one instance per input channel (set and reset are identical and independent up to arbitration):
  - Synchroniser: two flip-flops in series. Stage 1 samples the raw input; stage 2 gives the synchronised value `sy`.
  - Debounce:
    - If sy == lvl: cnt <= 0.
    - If sy != lvl and cnt < DEBOUNCE-1: cnt <= cnt+1.
    - If sy != lvl and cnt == DEBOUNCE-1: lvl <= sy, cnt <= 0.
    - lvl therefore changes only after DEBOUNCE consecutive edges with sy != lvl.
    - Any single cycle with sy == lvl restarts the count.
  - Edge detect: lvl_d <= lvl every cycle. A rise is `lvl & ~lvl_d`. Falling edges produce no pulse.
- Output stage (registered, evaluated every edge):
  - Set rise only: s <= 1, r <= 0, conflict <= 0.
  - Reset rise only: r <= 1, s <= 0, conflict <= 0.
  - Both rises on the same cycle: s <= 0, r <= 0, conflict <= 1.
  - Neither: all three <= 0.
  - Invariant: s & r == 0 at all times, including during and after reset.
- Latency:
  - Take the raw input stable at 1 from before edge E0, where E0 is the first edge that samples it.
  - sy=1 after E1.
  - lvl=1 after edge E(DEBOUNCE+1).
  - s=1 for exactly one cycle after edge E(DEBOUNCE+2), 0 again after E(DEBOUNCE+3).
  - With DEBOUNCE=4, s is high between E6 and E7.
- Boundary conditions:
  - Glitches or bounces: an input whose sy disagrees with lvl for fewer than DEBOUNCE consecutive cycles never changes lvl and never pulses.
  - Held input: produces exactly one pulse per debounced 0→1 transition, regardless of how long it is held.
  - Input high at reset release: treated as a rising edge, since lvl starts at 0. One pulse after DEBOUNCE+3 edges.
  - Reset mid-count or mid-pulse: the pulse or count is aborted. No pulse is emitted for the interrupted transition except via the previous rule.
  - Counter wrap: cnt never exceeds DEBOUNCE-1, so no wrap-around is possible.
  - Overlapping set and reset presses: rises on different cycles produce separate s and r pulses, even one cycle apart. Only exact-same-cycle rises are suppressed and flagged.

Test Plan:
1. Reset values: rst_n=0 with both buttons 1, toggle ck → s=r=conflict=set_lvl=rst_lvl=0. Release rst_n with buttons still 1 → s and r each assert? No: both rise together, so s=r=0 and conflict=1 exactly one cycle, 7 edges after release (DEBOUNCE=4).
2. Clean set press: set_btn 0→1 before E0, held 20 cycles → set_lvl=1 after E5; s=1 only between E6 and E7; r=0 and conflict=0 throughout.
3. Bounce rejection: set_btn toggles with a period of 2 cycles for 12 cycles, then settles at 1 → no s pulse during bouncing; exactly one s pulse 7 edges after the last transition.
4. Short glitch: rst_btn high for 3 cycles only → rst_lvl stays 0 and r stays 0.
5. Staggered presses: rst_btn rises one cycle after set_btn → s pulse, then r pulse on the next cycle; never simultaneous; conflict stays 0.
6. Reset mid-operation: set_btn rises, rst_n pulsed low at E3, set_btn kept at 1 → no pulse around E6. A single s pulse appears 7 edges after rst_n release. The invariant s&r==0 is asserted every cycle across all tests.

Source files
------------

// File: rtl/sr_pulse_driver.sv
// Set/reset excitation for an SR flip-flop: synchronises and debounces two raw buttons,
// turns each debounced rising edge into a one-cycle s or r pulse, never both at once.
module sr_pulse_driver #(
    parameter int DEBOUNCE = 4
) (
    input  logic ck,
    input  logic rst_n,
    input  logic set_btn,
    input  logic rst_btn,
    output logic s,
    output logic r,
    output logic conflict,
    output logic set_lvl,
    output logic rst_lvl
);
    localparam int CW = $clog2(DEBOUNCE);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    // Bit 0 is the set channel, bit 1 the reset channel throughout.
    logic [1:0]         meta_q, meta_d;
    logic [1:0]         sy_q, sy_d;
    logic [1:0]         lvl_q, lvl_d;
    logic [1:0]         prev_q, prev_d;
    logic [1:0][CW-1:0] cnt_q, cnt_d;
    logic               s_q, s_d;
    logic               r_q, r_d;
    logic               conflict_q, conflict_d;
    logic [1:0]         rise;

    always_comb begin
        meta_d = {rst_btn, set_btn};
        sy_d   = meta_q;
        prev_d = lvl_q;
        lvl_d  = lvl_q;
        cnt_d  = '0;
        for (int ch = 0; ch < 2; ch++) begin
            // Count consecutive disagreeing cycles; any agreement leaves cnt_d at zero.
            if (sy_q[ch] != lvl_q[ch]) begin
                if (cnt_q[ch] == CNT_MAX) begin
                    lvl_d[ch] = sy_q[ch];
                end else begin
                    cnt_d[ch] = cnt_q[ch] + CW'(1);
                end
            end
        end

        rise       = lvl_q & ~prev_q;
        s_d        = rise[0] & ~rise[1];
        r_d        = rise[1] & ~rise[0];
        conflict_d = rise[0] & rise[1];
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            meta_q     <= '0;
            sy_q       <= '0;
            lvl_q      <= '0;
            prev_q     <= '0;
            cnt_q      <= '0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            meta_q     <= meta_d;
            sy_q       <= sy_d;
            lvl_q      <= lvl_d;
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            s_q        <= s_d;
            r_q        <= r_d;
            conflict_q <= conflict_d;
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign conflict = conflict_q;
    assign set_lvl  = lvl_q[0];
    assign rst_lvl  = lvl_q[1];

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Bench for sr_pulse_driver: directed scenarios plus randomized button traffic,
// all compared cycle by cycle against a sliding-window reference model.
module tb_sr_pulse_driver;
    localparam int DB = 4;

    logic ck;
    logic rst_n;
    logic set_btn;
    logic rst_btn;
    logic s;
    logic r;
    logic conflict;
    logic set_lvl;
    logic rst_lvl;

    int n_checks;
    int n_errors;

    // Reference model state: raw samples in flight, debounced levels, their history.
    bit [1:0]   m_s1;
    bit [1:0]   m_sy;
    bit [1:0]   m_lvl;
    bit [1:0]   m_prev;
    bit         win0[$];
    bit         win1[$];
    logic [4:0] exp_q[$];

    int cyc, first_s, first_r, first_c, first_sl;
    int n_s, n_r, n_c, n_rl;

    sr_pulse_driver #(.DEBOUNCE(DB)) dut (
        .ck       (ck),
        .rst_n    (rst_n),
        .set_btn  (set_btn),
        .rst_btn  (rst_btn),
        .s        (s),
        .r        (r),
        .conflict (conflict),
        .set_lvl  (set_lvl),
        .rst_lvl  (rst_lvl)
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_clear();
        m_s1   = '0;
        m_sy   = '0;
        m_lvl  = '0;
        m_prev = '0;
        win0.delete();
        win1.delete();
    endfunction

    // A level flips once the last DB synchronised samples taken since the previous
    // flip all disagree with it.
    function automatic bit window_flip(input int ch, input bit sy, input bit lvl);
        bit all_diff;
        if (ch == 0) begin
            win0.push_back(sy);
            if (win0.size() > DB) void'(win0.pop_front());
            all_diff = (win0.size() == DB);
            foreach (win0[i]) if (win0[i] == lvl) all_diff = 1'b0;
            if (all_diff) win0.delete();
        end else begin
            win1.push_back(sy);
            if (win1.size() > DB) void'(win1.pop_front());
            all_diff = (win1.size() == DB);
            foreach (win1[i]) if (win1[i] == lvl) all_diff = 1'b0;
            if (all_diff) win1.delete();
        end
        return all_diff;
    endfunction

    task automatic model_edge();
        bit rise0, rise1, ms, mr, mc;
        bit [1:0] nl;
        if (!rst_n) begin
            exp_q.push_back(5'b0);
            return;
        end
        rise0 = m_lvl[0] && !m_prev[0];
        rise1 = m_lvl[1] && !m_prev[1];
        ms = rise0 && !rise1;
        mr = rise1 && !rise0;
        mc = rise0 && rise1;
        nl = m_lvl;
        if (window_flip(0, m_sy[0], m_lvl[0])) nl[0] = !m_lvl[0];
        if (window_flip(1, m_sy[1], m_lvl[1])) nl[1] = !m_lvl[1];
        m_prev = m_lvl;
        m_lvl  = nl;
        m_sy   = m_s1;
        m_s1   = {rst_btn, set_btn};
        exp_q.push_back({mc, mr, ms, m_lvl[1], m_lvl[0]});
    endtask

    task automatic mark();
        cyc = 0;
        first_s = 0; first_r = 0; first_c = 0; first_sl = 0;
        n_s = 0; n_r = 0; n_c = 0; n_rl = 0;
    endtask

    task automatic step();
        logic [4:0] e;
        model_edge();
        @(posedge ck);
        #1;
        e = exp_q.pop_front();
        cyc++;
        check("s",        32'(s),        32'(e[2]));
        check("r",        32'(r),        32'(e[3]));
        check("conflict", 32'(conflict), 32'(e[4]));
        check("set_lvl",  32'(set_lvl),  32'(e[0]));
        check("rst_lvl",  32'(rst_lvl),  32'(e[1]));
        check("s_and_r",  32'(s & r),    32'd0);
        if (s === 1'b1) begin n_s++; if (first_s == 0) first_s = cyc; end
        if (r === 1'b1) begin n_r++; if (first_r == 0) first_r = cyc; end
        if (conflict === 1'b1) begin n_c++; if (first_c == 0) first_c = cyc; end
        if (set_lvl === 1'b1 && first_sl == 0) first_sl = cyc;
        if (rst_lvl === 1'b1) n_rl++;
    endtask

    task automatic drive(input logic set_v, input logic rst_v);
        set_btn = set_v;
        rst_btn = rst_v;
    endtask

    task automatic set_reset(input logic v);
        rst_n = v;
        if (!v) model_clear();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        mark();
        drive(1'b1, 1'b1);
        set_reset(1'b0);

        // Reset with both buttons held, then release: simultaneous rise -> conflict only.
        repeat (3) step();
        set_reset(1'b1);
        mark();
        repeat (10) step();
        check("t1_conflict_edge", first_c, DB + 3);
        check("t1_conflict_count", n_c, 1);
        check("t1_no_s", n_s, 0);
        check("t1_no_r", n_r, 0);
        drive(1'b0, 1'b0);
        repeat (12) step();

        // Clean set press held for 20 cycles.
        drive(1'b1, 1'b0);
        mark();
        repeat (20) step();
        check("t2_set_lvl_edge", first_sl, DB + 2);
        check("t2_s_edge", first_s, DB + 3);
        check("t2_s_count", n_s, 1);
        check("t2_no_r", n_r, 0);
        check("t2_no_conflict", n_c, 0);
        drive(1'b0, 1'b0);
        repeat (12) step();

        // Bouncing set button, then a settled press.
        mark();
        for (int i = 0; i < 12; i++) begin
            drive((i % 2) == 0, 1'b0);
            step();
        end
        check("t3_no_s_bounce", n_s, 0);
        drive(1'b1, 1'b0);
        mark();
        repeat (15) step();
        check("t3_s_edge", first_s, DB + 3);
        check("t3_s_count", n_s, 1);
        drive(1'b0, 1'b0);
        repeat (12) step();

        // Three-cycle glitch on the reset button.
        mark();
        drive(1'b0, 1'b1);
        repeat (3) step();
        drive(1'b0, 1'b0);
        repeat (12) step();
        check("t4_no_rst_lvl", n_rl, 0);
        check("t4_no_r", n_r, 0);

        // Reset button rises one cycle after set button.
        drive(1'b1, 1'b0);
        mark();
        step();
        drive(1'b1, 1'b1);
        repeat (15) step();
        check("t5_s_edge", first_s, DB + 3);
        check("t5_r_edge", first_r, DB + 4);
        check("t5_s_count", n_s, 1);
        check("t5_r_count", n_r, 1);
        check("t5_no_conflict", n_c, 0);
        drive(1'b0, 1'b0);
        repeat (12) step();

        // Reset pulsed mid-debounce while set stays held.
        drive(1'b1, 1'b0);
        mark();
        repeat (3) step();
        set_reset(1'b0);
        repeat (2) step();
        check("t6_no_s_before", n_s, 0);
        set_reset(1'b1);
        mark();
        repeat (12) step();
        check("t6_s_edge", first_s, DB + 3);
        check("t6_s_count", n_s, 1);
        drive(1'b0, 1'b0);
        repeat (12) step();

        // Randomized button traffic with occasional resets.
        for (int seg = 0; seg < 80; seg++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 9) == 0) begin
                set_reset(1'b0);
                repeat ($urandom_range(1, 2)) step();
                set_reset(1'b1);
            end
            repeat ($urandom_range(1, 10)) step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
